fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage directly upstream of the instruction memory. It owns the fetch program counter, drives the memory's word address, and captures the returned 32-bit instruction into an instruction register. It presents that register to the decode/control stage through a valid/ready handshake, applies taken branches with a one-cycle bubble, and stops fetching after a halt instruction.

## Interface
Parameters:
- ADDR_W, 16, word-address width; matches the instruction memory's 16-bit word-addressed port
- INSTR_W, 32, instruction width
- RESET_PC, 16'h0000, first fetch address after reset

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_f  in  1  synchronous, active-low reset
- im_addr  out  ADDR_W  word address to the instruction memory; combinationally equals fetch_pc
- im_data  in  INSTR_W  instruction from the memory; treated as valid in the same cycle im_addr is driven
- ir  out  INSTR_W  instruction register presented to decode
- ir_pc  out  ADDR_W  word address of the instruction held in ir
- ir_valid  out  1  ir holds a live instruction
- ir_ready  in  1  decode accepts ir this cycle
- br_take  in  1  taken branch; asserted by decode together with ir_ready while accepting the branch in ir
- br_rel  in  1  1 = target is ir_pc + 1 + br_target; 0 = target is br_target
- br_target  in  ADDR_W  absolute address, or two's-complement word offset
- halted  out  1  fetch stopped after a halt instruction was accepted

## Operation
- Internal state: fetch_pc (ADDR_W), ir, ir_pc, ir_valid, and FSM state in {FETCH, DRAIN, HALT}.
- Reset values: fetch_pc = RESET_PC, ir = 0, ir_pc = RESET_PC, ir_valid = 0, halted = 0, state = FETCH.
- accept = ir_valid & ir_ready. capture = (state == FETCH) & (!ir_valid | ir_ready) & !(accept & br_take).
- On capture: ir <= im_data; ir_pc <= fetch_pc; ir_valid <= 1; fetch_pc <= fetch_pc + 1, wrapping modulo 2^ADDR_W (FFFF -> 0000).
- On accept without a new capture: ir_valid <= 0.
- Stall: while ir_valid & !ir_ready, ir, ir_pc, ir_valid and fetch_pc hold.
- Branch (accept & br_take):
  - fetch_pc <= target and ir_valid <= 0, discarding the wrong-path im_data.
  - Relative targets use ir_pc + 1 + br_target, truncated to ADDR_W bits.
  - State goes to FETCH from FETCH or DRAIN.
  - br_take is ignored when accept is 0.
- Halt: the opcode is ir[31:28]; the halt opcode is OP_HLT = 4'hF.
  - Capturing an OP_HLT word moves the FSM FETCH -> DRAIN. No capture occurs in DRAIN.
  - Accepting OP_HLT in DRAIN moves the FSM to HALT, with ir_valid <= 0 and halted <= 1.
- HALT is left only by reset. In HALT, ir_ready and br_take have no effect and im_addr holds.
- Reset asserted mid-stall, mid-branch or in HALT restores all reset values at the next edge. It has priority over every other event.

## Timing
- First ir_valid = 1 after the first rising edge with rst_f = 1, carrying im_data at RESET_PC.
- Throughput: one instruction per cycle while ir_ready = 1 and no branch is taken.
- Branch penalty:
  - Branch accepted at edge N -> ir_valid = 0 during cycle N..N+1.
  - The target instruction is valid after edge N+1.
- Halt: halted rises at the edge that accepts OP_HLT and stays 1.
- im_addr changes only at clock edges and never glitches from handshake inputs.

## Structure
- Shared package sisc_fetch_pkg holds:
  - OPCODE_HI = 31 and OPCODE_LO = 28
  - OP_HLT = 4'hF
  - FSM state enum {FETCH, DRAIN, HALT}
  - ADDR_W and INSTR_W defaults
- One sub-module, fetch_target: a combinational branch-target mux/adder that takes ir_pc, br_rel and br_target and outputs the target.
- The bench instantiates fetch_unit with the instruction memory, loaded from a test-specific data file.

## Test plan
- Reset and streaming: rst_f low 2 cycles, memory words 0..3 = 10000001, 10000002, 10000003, 10000004, ir_ready = 1 -> ir shows them on consecutive cycles, ir_pc = 0, 1, 2, 3.
- Stall: drop ir_ready for 3 cycles while ir_pc = 2 -> ir, ir_pc = 2 and im_addr = 3 hold; resuming gives ir_pc = 3 on the next edge.
- Absolute branch: accept at ir_pc = 4 with br_take = 1, br_rel = 0, br_target = 0020 -> one bubble, then ir_pc = 0020 with ir = mem[0x20].
- Relative and wrap branches:
  - Branch at ir_pc = 0010 with br_rel = 1, br_target = FFFE -> next ir_pc = 000F.
  - Sequential fetch from FFFF -> next ir_pc = 0000.
- Halt: mem[5] = F0000000 -> no capture after it; halted = 1 at its acceptance, ir_valid = 0 and im_addr frozen for 10 cycles despite ir_ready/br_take toggling.
- Reset mid-operation: assert rst_f = 0 during a stall and again in HALT -> next edge ir_valid = 0, halted = 0, im_addr = 0000.

Source files
------------

// File: rtl/sisc_fetch_pkg.sv
// Shared definitions for the SISC instruction-fetch stage.
//   - default address / instruction widths
//   - opcode field position and the halt opcode
//   - fetch FSM state encoding
package sisc_fetch_pkg;

  localparam int ADDR_W_DEFAULT  = 16;
  localparam int INSTR_W_DEFAULT = 32;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 28;

  localparam logic [3:0] OP_HLT = 4'hF;

  // FETCH : normal streaming
  // DRAIN : a halt word sits in ir; nothing more is fetched
  // HALT  : halt accepted; only reset leaves this state
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, the instruction memory and decode.
//
// Handshake: ir is transferred on every rising edge where ir_valid and
// ir_ready are both 1. While ir_valid is 1 and ir_ready is 0 the producer
// holds ir / ir_pc / ir_valid stable. br_take is only meaningful in a cycle
// where that transfer happens.
//
// master : the fetch unit
// slave  : memory + decode environment
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
) ();
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_data;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_valid;
  logic               ir_ready;
  logic               br_take;
  logic               br_rel;
  logic [ADDR_W-1:0]  br_target;
  logic               halted;

  modport master (
    output im_addr, ir, ir_pc, ir_valid, halted,
    input  im_data, ir_ready, br_take, br_rel, br_target
  );

  modport slave (
    input  im_addr, ir, ir_pc, ir_valid, halted,
    output im_data, ir_ready, br_take, br_rel, br_target
  );
endinterface

// File: rtl/fetch_target.sv
// Branch-target calculation (purely combinational).
//   ir_pc     : word address of the branch instruction
//   br_rel    : 1 = relative (ir_pc + 1 + br_target), 0 = absolute
//   br_target : absolute address or two's-complement word offset
//   target    : resulting fetch address, truncated to ADDR_W bits
module fetch_target #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] ir_pc,
  input  logic              br_rel,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] target
);

  // Modular addition makes a negative offset work without sign extension.
  assign target = br_rel ? (ir_pc + ADDR_W'(1) + br_target) : br_target;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
//   clk       : rising-edge clock
//   rst_f     : synchronous active-low reset
//   bus       : fetch_unit_if master (memory address/data, ir handshake,
//               branch request, halted flag)
//   state_dbg : current FSM state, for observation only
// Owns fetch_pc, drives the memory word address, captures the returned
// word into ir, applies taken branches with one bubble and stops after an
// accepted halt instruction.
module fetch_unit
  import sisc_fetch_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEFAULT,
  parameter int              INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_f,
  fetch_unit_if.master bus,
  output fetch_state_e state_dbg
);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0]  ir_pc_q;
  logic               ir_valid_q;
  logic [ADDR_W-1:0]  target;

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic accept;
  logic branch;
  logic capture;
  logic im_is_hlt;
  logic ir_is_hlt;

  fetch_target #(.ADDR_W(ADDR_W)) u_target (
    .ir_pc     (ir_pc_q),
    .br_rel    (bus.br_rel),
    .br_target (bus.br_target),
    .target    (target)
  );

  // In HALT ir_valid is 0, so accept/branch are inert there without any
  // extra gating.
  assign accept  = ir_valid_q & bus.ir_ready;
  assign branch  = accept & bus.br_take;
  // A taken branch blocks capture: the word at fetch_pc is wrong-path.
  assign capture = (state_q == FETCH) & (~ir_valid_q | bus.ir_ready) & ~branch;

  assign im_is_hlt = (bus.im_data[OPCODE_HI:OPCODE_LO] == OP_HLT);
  assign ir_is_hlt = (ir_q[OPCODE_HI:OPCODE_LO] == OP_HLT);

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (capture && im_is_hlt) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A branch taken on the draining word restarts fetching.
        if (branch) begin
          state_d = FETCH;
        end else if (accept && ir_is_hlt) begin
          state_d = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      fetch_pc   <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
    end else if (branch) begin
      fetch_pc   <= target;
      ir_valid_q <= 1'b0;
    end else if (capture) begin
      ir_q       <= bus.im_data;
      ir_pc_q    <= fetch_pc;
      ir_valid_q <= 1'b1;
      fetch_pc   <= fetch_pc + ADDR_W'(1);
    end else if (accept) begin
      ir_valid_q <= 1'b0;
    end
  end

  // im_addr is a pure register output, so handshake inputs cannot glitch it.
  assign bus.im_addr  = fetch_pc;
  assign bus.ir       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.halted   = (state_q == HALT);
  assign state_dbg    = state_q;

endmodule
